// File: rtl/dkong3_objram_sink_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dkong3_objram_sink_pkg
//  Description : Shared constants and FSM state type for the sprite DMA sink.
//  Revision    : 1.0 - initial release
// ============================================================================
package dkong3_objram_sink_pkg;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int CW = 9;
    localparam logic [AW-1:0] XFER_LEN = 10'h19F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dkong3_objram_dp.sv
`default_nettype none
// ============================================================================
//  Module      : dkong3_objram_dp
//  Description : Simple dual-port object RAM, sync write, registered read.
//  Revision    : 1.0 - initial release
// ============================================================================
module dkong3_objram_dp #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dkong3_objram_sink.sv
`default_nettype none
// ============================================================================
//  Module      : dkong3_objram_sink
//  Description : Double-buffered object RAM fed by the sprite DMA, bank swap
//                on vblank entry, sprite scanner reads from the display bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module dkong3_objram_sink
    import dkong3_objram_sink_pkg::*;
(
    input  logic          I_CLK_12M,
    input  logic          I_RESET,
    input  logic [AW-1:0] I_DMAD_A,
    input  logic [DW-1:0] I_DMAD_D,
    input  logic          I_DMAD_CE,
    input  logic          I_VBLK_n,
    input  logic [AW-1:0] I_SCAN_A,
    output logic [DW-1:0] O_SCAN_D,
    output logic          O_WBANK,
    output logic          O_XFER_DONE,
    output logic          O_SEQ_ERR,
    output logic          O_FRAME_MISS,
    output logic [CW-1:0] O_BYTE_CNT
);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bank_q, bank_d;
    logic          done_q, done_d;
    logic          seq_q, seq_d;
    logic          miss_q, miss_d;
    logic          vblk_q;

    logic          w_vblk_fall;
    logic [CW-1:0] w_cnt_inc;
    logic          w_addr_zero;
    logic          w_addr_seq;
    logic          w_we;

    assign w_vblk_fall = vblk_q & ~I_VBLK_n;
    assign w_cnt_inc   = cnt_q + 9'd1;
    assign w_addr_zero = (I_DMAD_A == '0);
    assign w_addr_seq  = (I_DMAD_A == {1'b0, cnt_q});
    assign w_we        = I_DMAD_CE && (I_DMAD_A < XFER_LEN);

    always_ff @(posedge I_CLK_12M) begin
        if (I_RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bank_q  <= 1'b1;
            done_q  <= 1'b0;
            seq_q   <= 1'b0;
            miss_q  <= 1'b0;
            vblk_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            done_q  <= done_d;
            seq_q   <= seq_d;
            miss_q  <= miss_d;
            vblk_q  <= I_VBLK_n;
        end
    end

    // Swap is resolved first; a coincident strobe then sees the post-swap state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        done_d  = done_q;
        seq_d   = seq_q;
        miss_d  = 1'b0;

        if (w_vblk_fall) begin
            if (state_q == DONE) begin
                bank_d  = ~bank_q;
                done_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                miss_d = 1'b1;
            end
        end

        if (I_DMAD_CE) begin
            case (state_d)
                IDLE: begin
                    if (w_addr_zero) begin
                        state_d = RECV;
                        cnt_d   = 9'd1;
                        seq_d   = 1'b0;
                    end else begin
                        seq_d = 1'b1;
                    end
                end
                RECV: begin
                    if (w_addr_seq) begin
                        cnt_d = w_cnt_inc;
                        if ({1'b0, w_cnt_inc} == XFER_LEN) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else if (w_addr_zero) begin
                        cnt_d = 9'd1;
                        seq_d = 1'b1;
                    end else begin
                        seq_d   = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                DONE: begin
                    if (w_addr_zero) begin
                        state_d = RECV;
                        cnt_d   = 9'd1;
                        done_d  = 1'b0;
                        seq_d   = 1'b0;
                    end else begin
                        seq_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    dkong3_objram_dp #(
        .AW (AW + 1),
        .DW (DW)
    ) u_ram (
        .clk_i   (I_CLK_12M),
        .rst_i   (I_RESET),
        .we_i    (w_we),
        .waddr_i ({bank_d, I_DMAD_A}),
        .wdata_i (I_DMAD_D),
        .raddr_i ({~bank_q, I_SCAN_A}),
        .rdata_o (O_SCAN_D)
    );

    assign O_WBANK      = bank_q;
    assign O_XFER_DONE  = done_q;
    assign O_SEQ_ERR    = seq_q;
    assign O_FRAME_MISS = miss_q;
    assign O_BYTE_CNT   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dkong3_objram_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dkong3_objram_sink
//  Description : Directed self-checking bench for the sprite DMA object RAM sink.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dkong3_objram_sink;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] dmad_a;
    logic [7:0] dmad_d;
    logic       dmad_ce;
    logic       vblk_n;
    logic [9:0] scan_a;
    logic [7:0] scan_d;
    logic       wbank, xfer_done, seq_err, frame_miss;
    logic [8:0] byte_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       ce;
        logic [9:0] a;
        logic       vblk_n;
        logic [8:0] cnt;
        logic       seq;
        logic       done;
        logic       miss;
        logic       wbank;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    dkong3_objram_sink dut (
        .I_CLK_12M    (clk),
        .I_RESET      (rst),
        .I_DMAD_A     (dmad_a),
        .I_DMAD_D     (dmad_d),
        .I_DMAD_CE    (dmad_ce),
        .I_VBLK_n     (vblk_n),
        .I_SCAN_A     (scan_a),
        .O_SCAN_D     (scan_d),
        .O_WBANK      (wbank),
        .O_XFER_DONE  (xfer_done),
        .O_SEQ_ERR    (seq_err),
        .O_FRAME_MISS (frame_miss),
        .O_BYTE_CNT   (byte_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_flags(input string nm, input logic [8:0] cnt, input logic seq,
                             input logic done, input logic miss, input logic wb);
        chk({nm, ".cnt"},   byte_cnt,   cnt);
        chk({nm, ".seq"},   seq_err,    seq);
        chk({nm, ".done"},  xfer_done,  done);
        chk({nm, ".miss"},  frame_miss, miss);
        chk({nm, ".wbank"}, wbank,      wb);
    endtask

    task automatic stream(input int lo, input int hi, input logic [7:0] key);
        for (int a = lo; a <= hi; a++) begin
            dmad_ce = 1'b1;
            dmad_a  = 10'(a);
            dmad_d  = 8'(a) ^ key;
            tick();
        end
        dmad_ce = 1'b0;
    endtask

    task automatic add(input logic ce, input logic [9:0] a, input logic vb, input logic [8:0] cnt,
                       input logic seq, input logic done, input logic miss, input logic wb);
        vec_t v;
        v.ce = ce; v.a = a; v.vblk_n = vb; v.cnt = cnt;
        v.seq = seq; v.done = done; v.miss = miss; v.wbank = wb;
        tbl.push_back(v);
    endtask

    initial begin
        // Starts in RECV at cnt 0x100, write bank 0, after a missed frame.
        add(1'b1, 10'h000, 1'b1, 9'h001, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int a = 1; a <= 32; a++) begin
            add(1'b1, 10'(a), 1'b1, 9'(a + 1), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        add(1'b0, 10'h055, 1'b1, 9'h021, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 10'h030, 1'b1, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 10'h000, 1'b1, 9'h001, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 10'h001, 1'b1, 9'h002, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 10'h1A0, 1'b1, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 10'h000, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 10'h000, 1'b1, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 10'h005, 1'b1, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 10'h19F, 1'b1, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);

        rst = 1'b1; dmad_ce = 1'b0; dmad_a = '0; dmad_d = '0; vblk_n = 1'b1; scan_a = '0;
        tick(); tick();
        chk_flags("reset", 9'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset.scan_d", scan_d, 8'h00);
        rst = 1'b0;

        // Full frame into bank 1, then swap.
        stream(0, 'h19E, 8'h5A);
        chk_flags("full", 9'h19F, 1'b0, 1'b1, 1'b0, 1'b1);
        vblk_n = 1'b0; tick();
        chk_flags("swap1", 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        vblk_n = 1'b1; scan_a = 10'h010; tick();
        chk("swap1.scan_d", scan_d, 8'h4A);

        // Partial frame: miss pulse, no swap.
        stream(0, 'hFF, 8'hA5);
        chk_flags("part", 9'h100, 1'b0, 1'b0, 1'b0, 1'b0);
        vblk_n = 1'b0; tick();
        chk_flags("miss", 9'h100, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_flags("miss_end", 9'h100, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("miss.scan_d", scan_d, 8'h4A);
        vblk_n = 1'b1; tick();

        foreach (tbl[i]) begin
            dmad_ce = tbl[i].ce;
            dmad_a  = tbl[i].a;
            dmad_d  = tbl[i].a[7:0] ^ 8'h5A;
            vblk_n  = tbl[i].vblk_n;
            tick();
            chk_flags($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].seq, tbl[i].done,
                      tbl[i].miss, tbl[i].wbank);
        end
        dmad_ce = 1'b0; vblk_n = 1'b1;

        // Last byte coincides with vblank entry: no swap, miss; next entry swaps.
        stream(0, 'h19D, 8'hC3);
        chk_flags("pre_last", 9'h19E, 1'b0, 1'b0, 1'b0, 1'b0);
        dmad_ce = 1'b1; dmad_a = 10'h19E; dmad_d = 8'h9E ^ 8'hC3; vblk_n = 1'b0;
        tick();
        dmad_ce = 1'b0;
        chk_flags("last_vblk", 9'h19F, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_flags("last_hold", 9'h19F, 1'b0, 1'b1, 1'b0, 1'b0);
        vblk_n = 1'b1; tick();
        vblk_n = 1'b0; tick();
        chk_flags("swap2", 9'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        vblk_n = 1'b1; scan_a = 10'h010; tick();
        chk("swap2.scan_d", scan_d, 8'hD3);
        scan_a = 10'h19E; tick();
        chk("swap2.scan_last", scan_d, 8'h5D);

        // Overwrite in DONE: restart cancels the pending swap.
        stream(0, 'h19E, 8'h11);
        chk_flags("full3", 9'h19F, 1'b0, 1'b1, 1'b0, 1'b1);
        stream(7, 7, 8'h11);
        chk_flags("done_bad", 9'h19F, 1'b1, 1'b1, 1'b0, 1'b1);
        stream(0, 0, 8'h11);
        chk_flags("done_restart", 9'h001, 1'b0, 1'b0, 1'b0, 1'b1);
        vblk_n = 1'b0; tick();
        chk_flags("no_swap", 9'h001, 1'b0, 1'b0, 1'b1, 1'b1);
        vblk_n = 1'b1; scan_a = 10'h010; tick();
        chk("no_swap.scan_d", scan_d, 8'hD3);

        // Reset mid-transfer.
        stream(1, 'h7F, 8'h11);
        chk_flags("mid", 9'h080, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1; tick();
        chk_flags("rst_mid", 9'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_mid.scan_d", scan_d, 8'h00);
        rst = 1'b0; tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
